// File: rtl/cprv_lsu_stage.sv
// Memory-access stage: sized loads/stores over valid/ready dmem request and response channels.
// Build option: define MISALIGN_TRAP_EN to trap misaligned/illegal accesses instead of issuing them.
module cprv_lsu_stage #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 64,
  parameter int IMM_WIDTH  = 32,
  parameter int STRB_WIDTH = DATA_WIDTH/8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  valid_mem_i,
  output logic                  ready_mem_o,
  input  logic [6:0]            opcode_mem_i,
  input  logic [2:0]            funct3_mem_i,
  input  logic [4:0]            rd_addr_mem_i,
  input  logic                  rd_en_mem_i,
  input  logic [IMM_WIDTH-1:0]  imm_data_mem_i,
  input  logic [DATA_WIDTH-1:0] rs2_data_mem_i,
  input  logic [DATA_WIDTH-1:0] alu_out_mem_i,
  output logic                  valid_wb_o,
  input  logic                  ready_wb_i,
  output logic [4:0]            rd_addr_wb_o,
  output logic                  rd_en_wb_o,
  output logic [6:0]            opcode_wb_o,
  output logic [IMM_WIDTH-1:0]  imm_data_wb_o,
  output logic [DATA_WIDTH-1:0] result_wb_o,
  output logic                  exc_wb_o,
  output logic                  valid_dmem_o,
  input  logic                  ready_dmem_i,
  output logic [ADDR_WIDTH-1:0] addr_dmem_o,
  output logic [DATA_WIDTH-1:0] wdata_dmem_o,
  output logic [STRB_WIDTH-1:0] wstrb_dmem_o,
  output logic                  w_en_dmem_o,
  input  logic                  valid_dmem_resp_i,
  output logic                  ready_dmem_resp_o,
  input  logic [DATA_WIDTH-1:0] rdata_dmem_i
);

  localparam int         OFF_W    = $clog2(STRB_WIDTH);
  localparam logic [1:0] FULL_SZ  = 2'(OFF_W);
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP, S_WB} state_e;

  function automatic logic [STRB_WIDTH-1:0] size_strb(input logic [1:0] sz);
    case (sz)
      2'd0:    return STRB_WIDTH'(1'b1);
      2'd1:    return STRB_WIDTH'(2'b11);
      2'd2:    return STRB_WIDTH'(4'hF);
      default: return '1;
    endcase
  endfunction

  function automatic logic [DATA_WIDTH-1:0] size_dmask(input logic [1:0] sz);
    case (sz)
      2'd0:    return DATA_WIDTH'(8'hFF);
      2'd1:    return DATA_WIDTH'(16'hFFFF);
      2'd2:    return DATA_WIDTH'(32'hFFFF_FFFF);
      default: return '1;
    endcase
  endfunction

`ifdef MISALIGN_TRAP_EN
  function automatic logic [OFF_W-1:0] size_align(input logic [1:0] sz);
    case (sz)
      2'd0:    return '0;
      2'd1:    return OFF_W'(1);
      2'd2:    return OFF_W'(3);
      default: return OFF_W'(7);
    endcase
  endfunction
`endif

  state_e                state_q, state_d;
  logic [4:0]            rd_addr_q, rd_addr_d;
  logic                  rd_en_q, rd_en_d;
  logic [6:0]            opcode_q, opcode_d;
  logic [IMM_WIDTH-1:0]  imm_q, imm_d;
  logic [DATA_WIDTH-1:0] result_q, result_d;
  logic                  exc_q, exc_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [STRB_WIDTH-1:0] wstrb_q, wstrb_d;
  logic                  w_en_q, w_en_d;
  logic [1:0]            sz_q, sz_d;
  logic                  sext_q, sext_d;
  logic [OFF_W-1:0]      off_q, off_d;

  logic                  accept;
  logic                  in_is_load, in_is_store, in_illegal, in_trap;
  logic [1:0]            in_sz;
  logic [OFF_W-1:0]      in_off;
  logic [ADDR_WIDTH-1:0] in_addr;
  logic [DATA_WIDTH-1:0] ld_shift, ld_mask, ld_top, ld_ext;
  logic                  ld_neg;

  assign ready_mem_o       = (state_q == S_IDLE) | ((state_q == S_WB) & ready_wb_i);
  assign accept            = valid_mem_i & ready_mem_o;
  assign valid_dmem_o      = (state_q == S_REQ);
  assign ready_dmem_resp_o = (state_q == S_RESP);
  assign valid_wb_o        = (state_q == S_WB);

  assign rd_addr_wb_o  = rd_addr_q;
  assign rd_en_wb_o    = rd_en_q;
  assign opcode_wb_o   = opcode_q;
  assign imm_data_wb_o = imm_q;
  assign result_wb_o   = result_q;
  assign exc_wb_o      = exc_q;
  assign addr_dmem_o   = addr_q;
  assign wdata_dmem_o  = wdata_q;
  assign wstrb_dmem_o  = wstrb_q;
  assign w_en_dmem_o   = w_en_q;

  // Incoming decode; an illegal size collapses to a full-bus access when not trapping.
  always_comb begin
    in_is_load  = (opcode_mem_i == OP_LOAD);
    in_is_store = (opcode_mem_i == OP_STORE);
    in_illegal  = (funct3_mem_i == 3'b111) |
                  ((DATA_WIDTH == 32) && (funct3_mem_i[1:0] == 2'b11));
    in_sz       = in_illegal ? FULL_SZ : funct3_mem_i[1:0];
    in_off      = alu_out_mem_i[OFF_W-1:0];
    in_addr     = ADDR_WIDTH'(alu_out_mem_i);
    in_addr[OFF_W-1:0] = '0;
`ifdef MISALIGN_TRAP_EN
    in_trap     = in_illegal | (|(in_off & size_align(in_sz)));
`else
    in_trap     = 1'b0;
`endif
  end

  // Load extraction: lane shift, truncate to size, extend from the top bit of the mask.
  always_comb begin
    ld_shift = rdata_dmem_i >> {in_off_zero(off_q), 3'b000};
    ld_mask  = size_dmask(sz_q);
    ld_top   = ld_mask & ~(ld_mask >> 1);
    ld_neg   = sext_q & (|(ld_shift & ld_top));
    ld_ext   = (ld_shift & ld_mask) | (ld_neg ? ~ld_mask : '0);
  end

  function automatic logic [OFF_W-1:0] in_off_zero(input logic [OFF_W-1:0] o);
    return o;
  endfunction

  always_comb begin
    state_d   = state_q;
    rd_addr_d = rd_addr_q;
    rd_en_d   = rd_en_q;
    opcode_d  = opcode_q;
    imm_d     = imm_q;
    result_d  = result_q;
    exc_d     = exc_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    w_en_d    = w_en_q;
    sz_d      = sz_q;
    sext_d    = sext_q;
    off_d     = off_q;

    case (state_q)
      S_REQ:  if (ready_dmem_i) state_d = S_RESP;
      S_RESP: if (valid_dmem_resp_i) begin
        if (!w_en_q) result_d = ld_ext;
        state_d = S_WB;
      end
      S_WB:   if (ready_wb_i) state_d = S_IDLE;
      default: ;
    endcase

    // A new accept overrides the WB->IDLE transition so back-to-back ops flow at full rate.
    if (accept) begin
      rd_addr_d = rd_addr_mem_i;
      rd_en_d   = rd_en_mem_i;
      opcode_d  = opcode_mem_i;
      imm_d     = imm_data_mem_i;
      exc_d     = 1'b0;
      if (in_is_load || in_is_store) begin
        result_d = '0;
        sz_d     = in_sz;
        sext_d   = ~funct3_mem_i[2];
        off_d    = in_off;
        if (in_trap) begin
          exc_d   = 1'b1;
          rd_en_d = 1'b0;
          state_d = S_WB;
        end else begin
          addr_d  = in_addr;
          wdata_d = in_is_store ? (rs2_data_mem_i << {in_off, 3'b000}) : '0;
          wstrb_d = in_is_store ? (size_strb(in_sz) << in_off) : '0;
          w_en_d  = in_is_store;
          state_d = S_REQ;
        end
      end else begin
        result_d = alu_out_mem_i;
        state_d  = S_WB;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      rd_addr_q <= '0;
      rd_en_q   <= 1'b0;
      opcode_q  <= '0;
      imm_q     <= '0;
      result_q  <= '0;
      exc_q     <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      w_en_q    <= 1'b0;
      sz_q      <= '0;
      sext_q    <= 1'b0;
      off_q     <= '0;
    end else begin
      state_q   <= state_d;
      rd_addr_q <= rd_addr_d;
      rd_en_q   <= rd_en_d;
      opcode_q  <= opcode_d;
      imm_q     <= imm_d;
      result_q  <= result_d;
      exc_q     <= exc_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      w_en_q    <= w_en_d;
      sz_q      <= sz_d;
      sext_q    <= sext_d;
      off_q     <= off_d;
    end
  end

endmodule

// File: tb/tb_cprv_lsu_stage.sv
// Scoreboard bench for cprv_lsu_stage: expected wb beats queued at accept, checked at wb handshake.
module tb_cprv_lsu_stage;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_ADD   = 7'b0110011;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid_mem_i = 1'b0;
  logic        ready_mem_o;
  logic [6:0]  opcode_mem_i = '0;
  logic [2:0]  funct3_mem_i = '0;
  logic [4:0]  rd_addr_mem_i = '0;
  logic        rd_en_mem_i = 1'b0;
  logic [31:0] imm_data_mem_i = '0;
  logic [63:0] rs2_data_mem_i = '0;
  logic [63:0] alu_out_mem_i = '0;
  logic        valid_wb_o;
  logic        ready_wb_i = 1'b1;
  logic [4:0]  rd_addr_wb_o;
  logic        rd_en_wb_o;
  logic [6:0]  opcode_wb_o;
  logic [31:0] imm_data_wb_o;
  logic [63:0] result_wb_o;
  logic        exc_wb_o;
  logic        valid_dmem_o;
  logic        ready_dmem_i = 1'b1;
  logic [63:0] addr_dmem_o;
  logic [63:0] wdata_dmem_o;
  logic [7:0]  wstrb_dmem_o;
  logic        w_en_dmem_o;
  logic        valid_dmem_resp_i = 1'b0;
  logic        ready_dmem_resp_o;
  logic [63:0] rdata_dmem_i = '0;

  cprv_lsu_stage dut (
    .clk(clk), .rst_n(rst_n),
    .valid_mem_i(valid_mem_i), .ready_mem_o(ready_mem_o),
    .opcode_mem_i(opcode_mem_i), .funct3_mem_i(funct3_mem_i),
    .rd_addr_mem_i(rd_addr_mem_i), .rd_en_mem_i(rd_en_mem_i),
    .imm_data_mem_i(imm_data_mem_i), .rs2_data_mem_i(rs2_data_mem_i),
    .alu_out_mem_i(alu_out_mem_i),
    .valid_wb_o(valid_wb_o), .ready_wb_i(ready_wb_i),
    .rd_addr_wb_o(rd_addr_wb_o), .rd_en_wb_o(rd_en_wb_o),
    .opcode_wb_o(opcode_wb_o), .imm_data_wb_o(imm_data_wb_o),
    .result_wb_o(result_wb_o), .exc_wb_o(exc_wb_o),
    .valid_dmem_o(valid_dmem_o), .ready_dmem_i(ready_dmem_i),
    .addr_dmem_o(addr_dmem_o), .wdata_dmem_o(wdata_dmem_o),
    .wstrb_dmem_o(wstrb_dmem_o), .w_en_dmem_o(w_en_dmem_o),
    .valid_dmem_resp_i(valid_dmem_resp_i), .ready_dmem_resp_o(ready_dmem_resp_o),
    .rdata_dmem_i(rdata_dmem_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] res;
    logic        exc;
    logic [4:0]  rd;
    logic        rd_en;
    logic [6:0]  op;
    logic [31:0] imm;
  } wb_exp_t;

  wb_exp_t sb[$];
  int      beat_cyc[$];
  int      cyc = 0;
  int      acc_cyc = 0;
  int      n_checks = 0;
  int      n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard consumer: every wb handshake must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n && valid_wb_o && ready_wb_i) begin
      beat_cyc.push_back(cyc);
      $display("wb beat @%0d: rd=%0d op=%b result=0x%h exc=%0b", cyc, rd_addr_wb_o,
               opcode_wb_o, result_wb_o, exc_wb_o);
      if (sb.size() == 0) begin
        check_eq("wb_unexpected_beat", 64'(sb.size()), 64'd1);
      end else begin
        wb_exp_t e;
        e = sb.pop_front();
        check_eq("wb_result", result_wb_o, e.res);
        check_eq("wb_exc", 64'(exc_wb_o), 64'(e.exc));
        check_eq("wb_rd_addr", 64'(rd_addr_wb_o), 64'(e.rd));
        check_eq("wb_rd_en", 64'(rd_en_wb_o), 64'(e.rd_en));
        check_eq("wb_opcode", 64'(opcode_wb_o), 64'(e.op));
        check_eq("wb_imm", 64'(imm_data_wb_o), 64'(e.imm));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_accept(input logic [6:0] op, input logic [2:0] f3, input logic [4:0] rd,
                           input logic [63:0] alu, input logic [63:0] rs2,
                           input logic [63:0] exp_res, input logic exp_exc, input logic exp_rd_en);
    wb_exp_t e;
    int n;
    valid_mem_i    = 1'b1;
    opcode_mem_i   = op;
    funct3_mem_i   = f3;
    rd_addr_mem_i  = rd;
    rd_en_mem_i    = 1'b1;
    alu_out_mem_i  = alu;
    rs2_data_mem_i = rs2;
    imm_data_mem_i = $urandom;
    n = 0;
    @(negedge clk);
    while (!ready_mem_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!ready_mem_o) check_eq("accept_timeout", 64'(ready_mem_o), 64'd1);
    e.res = exp_res; e.exc = exp_exc; e.rd = rd; e.rd_en = exp_rd_en;
    e.op = op; e.imm = imm_data_mem_i;
    sb.push_back(e);
    acc_cyc = cyc;
    $display("accept @%0d: op=%b f3=%b rd=%0d alu=0x%h", cyc, op, f3, rd, alu);
    tick();
    valid_mem_i = 1'b0;
  endtask

  task automatic dmem_serve(input logic [63:0] exp_addr, input logic [7:0] exp_strb,
                            input logic exp_wen, input logic [63:0] exp_wdata,
                            input logic [63:0] rdata);
    int n;
    n = 0;
    @(negedge clk);
    while (!valid_dmem_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_eq("dmem_req_valid", 64'(valid_dmem_o), 64'd1);
    check_eq("dmem_addr", addr_dmem_o, exp_addr);
    check_eq("dmem_wstrb", 64'(wstrb_dmem_o), 64'(exp_strb));
    check_eq("dmem_w_en", 64'(w_en_dmem_o), 64'(exp_wen));
    if (exp_wen) check_eq("dmem_wdata", wdata_dmem_o, exp_wdata);
    $display("dmem req @%0d: addr=0x%h strb=%b w_en=%0b", cyc, addr_dmem_o, wstrb_dmem_o, w_en_dmem_o);
    tick();
    valid_dmem_resp_i = 1'b1;
    rdata_dmem_i      = rdata;
    n = 0;
    @(negedge clk);
    while (!ready_dmem_resp_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_eq("dmem_resp_ready", 64'(ready_dmem_resp_o), 64'd1);
    tick();
    valid_dmem_resp_i = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_eq("sb_drained", 64'(sb.size()), 64'd0);
    tick();
  endtask

  initial begin
    int bb_start;
    logic [63:0] snap_addr;

    // Reset values while rst_n is held low
    repeat (2) @(negedge clk);
    check_eq("rst_ready_mem", 64'(ready_mem_o), 64'd1);
    check_eq("rst_valid_wb", 64'(valid_wb_o), 64'd0);
    check_eq("rst_valid_dmem", 64'(valid_dmem_o), 64'd0);
    check_eq("rst_ready_resp", 64'(ready_dmem_resp_o), 64'd0);
    check_eq("rst_result", result_wb_o, 64'd0);
    check_eq("rst_exc", 64'(exc_wb_o), 64'd0);
    check_eq("rst_addr_dmem", addr_dmem_o, 64'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Single ADD: valid_wb_o the cycle after accept
    do_accept(OP_ADD, 3'b000, 5'd1, 64'h1234, 64'd0, 64'h1234, 1'b0, 1'b1);
    @(negedge clk);
    check_eq("add_valid_next", 64'(valid_wb_o), 64'd1);
    check_eq("add_result_next", result_wb_o, 64'h1234);
    wait_drain();

    // Four back-to-back ADDs -> four consecutive wb beats
    bb_start = beat_cyc.size();
    for (int i = 0; i < 4; i++)
      do_accept(OP_ADD, 3'b000, 5'(2 + i), 64'(32'h100 * (i + 1)), 64'd0,
                64'(32'h100 * (i + 1)), 1'b0, 1'b1);
    wait_drain();
    check_eq("b2b_beats", 64'(beat_cyc.size() - bb_start), 64'd4);
    if (beat_cyc.size() >= bb_start + 4)
      check_eq("b2b_span", 64'(beat_cyc[bb_start + 3] - beat_cyc[bb_start]), 64'd3);

    // LB sign-extends byte 3, then LBU zero-extends the same data
    do_accept(OP_LOAD, 3'b000, 5'd6, 64'h1003, 64'd0, 64'hFFFF_FFFF_FFFF_FF80, 1'b0, 1'b1);
    dmem_serve(64'h1000, 8'h00, 1'b0, 64'd0, 64'h0000_0000_8000_0000);
    wait_drain();
    check_eq("lb_latency", 64'(beat_cyc[beat_cyc.size() - 1] - acc_cyc), 64'd3);
    do_accept(OP_LOAD, 3'b100, 5'd7, 64'h1003, 64'd0, 64'h80, 1'b0, 1'b1);
    dmem_serve(64'h1000, 8'h00, 1'b0, 64'd0, 64'h0000_0000_8000_0000);
    wait_drain();

    // SH into the top halfword lane
    do_accept(OP_STORE, 3'b001, 5'd8, 64'h1006, 64'hBEEF, 64'd0, 1'b0, 1'b1);
    dmem_serve(64'h1000, 8'hC0, 1'b1, 64'hBEEF_0000_0000_0000, 64'd0);
    wait_drain();

    // Back-pressure on both channels: request and wb outputs must hold
    ready_dmem_i = 1'b0;
    do_accept(OP_STORE, 3'b010, 5'd10, 64'h1008, 64'hDEAD_BEEF_CAFE_F00D, 64'd0, 1'b0, 1'b1);
    snap_addr = 64'h1008;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq("stall_dmem_valid", 64'(valid_dmem_o), 64'd1);
      check_eq("stall_dmem_addr", addr_dmem_o, snap_addr);
      check_eq("stall_dmem_wdata", wdata_dmem_o, 64'hDEAD_BEEF_CAFE_F00D);
      check_eq("stall_ready_mem", 64'(ready_mem_o), 64'd0);
    end
    tick();
    ready_dmem_i = 1'b1;
    ready_wb_i   = 1'b0;
    dmem_serve(64'h1008, 8'h0F, 1'b1, 64'hDEAD_BEEF_CAFE_F00D, 64'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("stall_wb_valid", 64'(valid_wb_o), 64'd1);
      check_eq("stall_wb_result", result_wb_o, 64'd0);
      check_eq("stall_wb_rd", 64'(rd_addr_wb_o), 64'd10);
      check_eq("stall_wb_ready_mem", 64'(ready_mem_o), 64'd0);
    end
    tick();
    ready_wb_i = 1'b1;
    wait_drain();

    // Misaligned LW
`ifdef MISALIGN_TRAP_EN
    do_accept(OP_LOAD, 3'b010, 5'd9, 64'h1002, 64'd0, 64'd0, 1'b1, 1'b0);
    @(negedge clk);
    check_eq("misal_no_req", 64'(valid_dmem_o), 64'd0);
    check_eq("misal_valid_wb", 64'(valid_wb_o), 64'd1);
    check_eq("misal_exc", 64'(exc_wb_o), 64'd1);
    wait_drain();
`else
    do_accept(OP_LOAD, 3'b010, 5'd9, 64'h1002, 64'd0, 64'h3344_5566, 1'b0, 1'b1);
    dmem_serve(64'h1000, 8'h00, 1'b0, 64'd0, 64'h1122_3344_5566_7788);
    wait_drain();
`endif

    // Reset while waiting for a load response
    do_accept(OP_LOAD, 3'b011, 5'd11, 64'h2000, 64'd0, 64'd0, 1'b0, 1'b1);
    @(negedge clk);
    check_eq("rstmid_req", 64'(valid_dmem_o), 64'd1);
    tick();
    @(negedge clk);
    check_eq("rstmid_in_resp", 64'(ready_dmem_resp_o), 64'd1);
    rst_n = 1'b0;
    #1;
    check_eq("rstmid_valid_wb", 64'(valid_wb_o), 64'd0);
    check_eq("rstmid_valid_dmem", 64'(valid_dmem_o), 64'd0);
    check_eq("rstmid_ready_resp", 64'(ready_dmem_resp_o), 64'd0);
    check_eq("rstmid_ready_mem", 64'(ready_mem_o), 64'd1);
    sb.delete();
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    do_accept(OP_ADD, 3'b000, 5'd12, 64'h5A5A, 64'd0, 64'h5A5A, 1'b0, 1'b1);
    @(negedge clk);
    check_eq("post_rst_valid", 64'(valid_wb_o), 64'd1);
    wait_drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
